// File: rtl/mag_pow_pkg.sv
// Shared constants and product-tree index helpers for the
// magnitude power basis generator.
package mag_pow_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int nstg(input int k);
        return (k <= 2) ? 0 : clog2(k - 1);
    endfunction

    function automatic int lat(input int mag_lat, input int k);
        return mag_lat + nstg(k) + 1;
    endfunction

    // multiply stage in which order k is produced
    function automatic int stg(input int k);
        return (k <= 1) ? 0 : clog2(k);
    endfunction

    function automatic int op_hi(input int k);
        return (k + 1) / 2;
    endfunction

    function automatic int op_lo(input int k);
        return k / 2;
    endfunction

    function automatic int one_q(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/mag_complex.sv
// Complex magnitude |x| = floor(sqrt(i^2 + q^2)), LAT register stages.
// Data path only, no reset.
module mag_complex #(
    parameter int W   = 20,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic [W-1:0] sig_i,
    input  logic [W-1:0] sig_q,
    output logic [W-1:0] mag
);

    logic signed [2*W-1:0] pi;
    logic signed [2*W-1:0] pq;
    logic [2*W-1:0]        sq;
    logic [W-1:0]          root;
    logic [W-1:0]          trial;

    assign pi = $signed(sig_i) * $signed(sig_i);
    assign pq = $signed(sig_q) * $signed(sig_q);
    assign sq = $unsigned(pi) + $unsigned(pq);

    // bitwise square root, MSB first
    always_comb begin
        root  = '0;
        trial = '0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = root | (W'(1) << b);
            if (({{W{1'b0}}, trial} * {{W{1'b0}}, trial}) <= sq)
                root = trial;
        end
    end

    if (LAT == 0) begin : g_comb
        assign mag = root;
    end else begin : g_pipe
        logic [W-1:0] p [1:LAT];
        always_ff @(posedge clk) begin
            p[1] <= root;
            for (int j = 2; j <= LAT; j++) p[j] <= p[j-1];
        end
        assign mag = p[LAT];
    end

endmodule

// File: rtl/mag_pow_mul.sv
// Registered W x W unsigned Q1.(W-1) multiply with round half up.
// MAG_POW_SAT_EN: saturate on overflow and pulse sat.
module mag_pow_mul #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         sat
);

    logic [2*W-1:0] full;
    logic [W:0]     rnd;

    assign full = a * b;
    assign rnd  = {1'b0, full[2*W-2:W-1]} + {{W{1'b0}}, full[W-2]};

`ifdef MAG_POW_SAT_EN
    always_ff @(posedge clk) begin
        if (full[2*W-1] | rnd[W]) begin
            res <= '1;
            sat <= 1'b1;
        end else begin
            res <= rnd[W-1:0];
            sat <= 1'b0;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = full[2*W-1] ^ rnd[W];

    always_ff @(posedge clk) begin
        res <= rnd[W-1:0];
        sat <= 1'b0;
    end
`endif

endmodule

// File: rtl/mag_pow_n.sv
// Magnitude power basis |x|^0..|x|^(K-1), balanced product tree.
// Optional saturation via MAG_POW_SAT_EN.
module mag_pow_n
    import mag_pow_pkg::*;
#(
    parameter int W       = 20,
    parameter int K       = 5,
    parameter int MAG_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [W-1:0]   sig_in_i,
    input  logic [W-1:0]   sig_in_q,
    output logic           out_valid,
    output logic [K*W-1:0] mag_out,
    output logic           ovf_flag
);

    localparam int NSTG = nstg(K);
    localparam int L    = lat(MAG_LAT, K) - 1;
    localparam logic [W-1:0] ONE_Q = W'(one_q(W));

    // taps[k][d]: order k, d cycles after it was produced
    logic [W-1:0]   taps [1:K-1][0:NSTG];
    logic [W-1:0]   mag;
    logic [L:0]     vp;
    logic [L:1]     vreg;
    logic [K-1:0]   sat_v;
    logic [K*W-1:0] nxt;

    mag_complex #(.W(W), .LAT(MAG_LAT)) u_mag (
        .clk   (clk),
        .sig_i (sig_in_i),
        .sig_q (sig_in_q),
        .mag   (mag)
    );

    assign taps[1][0]  = mag;
    assign vp          = {vreg, in_valid};
    assign sat_v[1:0]  = 2'b00;
    assign nxt[W-1:0]  = ONE_Q;

    for (genvar k = 1; k < K; k++) begin : g_ord
        if (k >= 2) begin : g_mul
            localparam int HI = op_hi(k);
            localparam int LO = op_lo(k);
            localparam int S  = stg(k);
            logic sat;
            mag_pow_mul #(.W(W)) u_mul (
                .clk (clk),
                .a   (taps[HI][S-1-stg(HI)]),
                .b   (taps[LO][S-1-stg(LO)]),
                .res (taps[k][0]),
                .sat (sat)
            );
            assign sat_v[k] = sat & vp[MAG_LAT+S];
        end
        if (NSTG > 0) begin : g_sr
            logic [W-1:0] sr [1:NSTG];
            always_ff @(posedge clk) begin
                sr[1] <= taps[k][0];
                for (int j = 2; j <= NSTG; j++) sr[j] <= sr[j-1];
            end
            for (genvar d = 1; d <= NSTG; d++) begin : g_tap
                assign taps[k][d] = sr[d];
            end
        end
        assign nxt[k*W +: W] = taps[k][NSTG-stg(k)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vreg      <= '0;
            out_valid <= 1'b0;
            mag_out   <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            vreg      <= vp[L-1:0];
            out_valid <= vp[L];
            if (vp[L]) mag_out <= nxt;
            if (|sat_v) ovf_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mag_pow_n.sv
// Scoreboard bench for mag_pow_n (W=20, K=5, MAG_LAT=1).
module tb_mag_pow_n;

    localparam int W       = 20;
    localparam int K       = 5;
    localparam int MAG_LAT = 1;
    localparam int LAT     = 4;

    typedef struct {
        logic [K*W-1:0] val;
        longint         at;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   sig_in_i;
    logic [W-1:0]   sig_in_q;
    logic           out_valid;
    logic [K*W-1:0] mag_out;
    logic           ovf_flag;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    bit     exp_ovf  = 1'b0;
    exp_t   sbq [$];
    exp_t   e;

    mag_pow_n #(.W(W), .K(K), .MAG_LAT(MAG_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sig_in_i  (sig_in_i),
        .sig_in_q  (sig_in_q),
        .out_valid (out_valid),
        .mag_out   (mag_out),
        .ovf_flag  (ovf_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint isqrt(input longint x);
        longint r;
        r = longint'($sqrt(real'(x)));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic build_exp(input int i, input int q,
                             output logic [K*W-1:0] v);
        longint p [K];
        longint full, r, mask;
        mask = (longint'(1) << W) - 1;
        p[0] = (longint'(1) << (W - 1)) - 1;
        p[1] = isqrt(longint'(i) * i + longint'(q) * q);
        for (int k = 2; k < K; k++) begin
            full = p[(k+1)/2] * p[k/2];
            r = ((full >> (W - 1)) & mask) + ((full >> (W - 2)) & 1);
`ifdef MAG_POW_SAT_EN
            if (((full >> (2*W - 1)) & 1) != 0 || r > mask) begin
                r = mask;
                exp_ovf = 1'b1;
            end
`else
            r = r & mask;
`endif
            p[k] = r;
        end
        v = '0;
        for (int k = 0; k < K; k++) v[k*W +: W] = W'(p[k]);
    endtask

    task automatic drive(input bit v, input int i, input int q);
        logic [K*W-1:0] ev;
        @(posedge clk);
        #1;
        in_valid = v;
        sig_in_i = W'(i);
        sig_in_q = W'(q);
        if (v) begin
            build_exp(i, q, ev);
            sbq.push_back('{val: ev, at: cyc + LAT});
        end
    endtask

    task automatic drain();
        int n;
        drive(1'b0, 0, 0);
        n = 0;
        while (sbq.size() > 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", sbq.size());
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out cyc=%0d got=%h want=none",
                         cyc, mag_out);
            end else begin
                e = sbq.pop_front();
                if (mag_out !== e.val) begin
                    failures++;
                    $display("FAIL out_value cyc=%0d got=%h want=%h",
                             cyc, mag_out, e.val);
                end
                checks++;
                if (cyc !== e.at) begin
                    failures++;
                    $display("FAIL out_cycle got=%0d want=%0d", cyc, e.at);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        sig_in_i = '0;
        sig_in_q = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        checks++;
        if (mag_out !== '0) begin
            failures++;
            $display("FAIL reset_mag got=%h want=0", mag_out);
        end
        checks++;
        if (ovf_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b want=0", ovf_flag);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_zero();
        drive(1'b1, 0, 0);
        drain();
    endtask

    task automatic test_half();
        drive(1'b1, 262144, 0);
        drive(1'b0, 0, 0);
        drive(1'b1, 0, -262144);
        drain();
    endtask

    task automatic test_stream();
        logic [7:0] pat;
        int iv, qv;
        pat = 8'b1101_0011;
        for (int n = 0; n < 16; n++) begin
            iv = int'($urandom_range(740000)) - 370000;
            qv = int'($urandom_range(740000)) - 370000;
            drive(pat[7 - (n % 8)], iv, qv);
        end
        drain();
        checks++;
        if (ovf_flag !== exp_ovf) begin
            failures++;
            $display("FAIL stream_ovf got=%b want=%b", ovf_flag, exp_ovf);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 524287, 0);
        drive(1'b1, 0, 524287);
        drive(1'b1, 1, 1);
        for (int n = 0; n < 5; n++)
            drive(1'b1, 100000 * n - 200000, 50000 * n);
        drain();
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 300000, 100000);
        drive(1'b1, 200000, -200000);
        drive(1'b1, -100000, 400000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        sbq.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_valid got=%b want=0", out_valid);
        end
        checks++;
        if (mag_out !== '0) begin
            failures++;
            $display("FAIL rstmid_mag got=%h want=0", mag_out);
        end
        repeat (8) @(posedge clk);
        drive(1'b1, 262144, 0);
        drain();
    endtask

    task automatic test_sat();
        drive(1'b1, -524288, -524288);
        drain();
        checks++;
        if (ovf_flag !== exp_ovf) begin
            failures++;
            $display("FAIL sat_ovf got=%b want=%b", ovf_flag, exp_ovf);
        end
        drive(1'b1, 1000, 2000);
        drain();
        checks++;
        if (ovf_flag !== exp_ovf) begin
            failures++;
            $display("FAIL sat_sticky got=%b want=%b", ovf_flag, exp_ovf);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf_flag !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear got=%b want=0", ovf_flag);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_half();
        test_stream();
        test_back_to_back();
        test_rst_mid();
        test_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
